// File: rtl/dc_miss_ctrl_2way.sv
// dc_miss_ctrl_2way: 2-way set-associative data cache tag store and miss/flush controller
// Ports: clk, rst_n (async active-low), rst_pipe (sync pipeline reset)
//   req_ld/req_st/req_adr : MA-stage request; stall/hit/hit_way : lookup result
//   ram_*                 : external data RAM read (1-cycle latency) and line-fill write
//   dcw_*                 : write-back bus request; dcr_*/rdat_m_* : line-read bus request/response
//   start_dcflush/dcflush_running : flush engine, present only when DC_FLUSH_EN is defined
module dc_miss_ctrl_2way #(
    parameter int IDXW = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rst_pipe,
    input  logic             req_ld,
    input  logic             req_st,
    input  logic [31:0]      req_adr,
    output logic             stall,
    output logic             hit,
    output logic             hit_way,
    output logic             ram_ren,
    output logic [IDXW:0]    ram_radr,
    input  logic [127:0]     ram_rdata,
    output logic             ram_wen,
    output logic [IDXW:0]    ram_wadr,
    output logic [127:0]     ram_wdata,
    output logic             dcw_start_rq,
    output logic [31:0]      dcw_in_addr,
    output logic [127:0]     dcw_in_data,
    input  logic             dcw_finish_wresp,
    output logic             dcr_start_rq,
    output logic [31:0]      dcr_rin_addr,
    input  logic [127:0]     rdat_m_data,
    input  logic             rdat_m_valid,
    input  logic             start_dcflush,
    output logic             dcflush_running
);
    localparam int SETS = 2 ** IDXW;
    localparam int TW = 24 - IDXW;
    typedef enum logic [2:0] {IDLE, WBRQ, MEMW, MEMR, FILL, FLCK, FLWB, FLWT} st_t;
    st_t state_q, state_d;
    logic [31:0]     adr_q;
    logic            vic_q;
    logic [IDXW:0]   cnt_q, cnt_d;
    logic [SETS-1:0] val_q [2];
    logic [SETS-1:0] dirty_q [2];
    logic [SETS-1:0] lru_q;
    logic [TW-1:0]   tag_q [2][SETS];
    logic [IDXW-1:0] idx, idx_q, cidx;
    logic [TW-1:0]   tag;
    logic            cached, m0, m1, idle, miss, vic, vdirty, cway, cdirty, last, flush_go, clear_all;
    logic            unused;
    assign idx    = req_adr[IDXW+3:4];
    assign tag    = req_adr[27:IDXW+4];
    assign idx_q  = adr_q[IDXW+3:4];
    assign cidx   = cnt_q[IDXW-1:0];
    assign cway   = cnt_q[IDXW];
    assign last   = &cnt_q;
    assign idle   = state_q == IDLE;
    assign cached = (req_ld | req_st) & (req_adr[31:30] != 2'b11);
    assign m0     = val_q[0][idx] & (tag_q[0][idx] == tag);
    assign m1     = val_q[1][idx] & (tag_q[1][idx] == tag);
    assign miss   = idle & cached & ~(m0 | m1);
    assign vic    = !val_q[0][idx] ? 1'b0 : !val_q[1][idx] ? 1'b1 : lru_q[idx];
    assign vdirty = dirty_q[vic][idx];
    assign cdirty = val_q[cway][cidx] & dirty_q[cway][cidx];
    assign unused = ^{req_adr[3:0], adr_q[3:0], start_dcflush};
`ifdef DC_FLUSH_EN
    assign flush_go        = start_dcflush;
    assign dcflush_running = (state_q == FLCK) | (state_q == FLWB) | (state_q == FLWT);
`else
    assign flush_go        = 1'b0;
    assign dcflush_running = 1'b0;
`endif
    // The flush ends by invalidating every line at once, whichever state finishes the last entry.
    assign clear_all = rst_pipe | (last & (((state_q == FLCK) & ~cdirty) | ((state_q == FLWT) & dcw_finish_wresp)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (miss) state_d = vdirty ? WBRQ : MEMR;
                else if (flush_go) begin
                    state_d = FLCK;
                    cnt_d   = '0;
                end
            end
            WBRQ: state_d = MEMW;
            MEMW: state_d = dcw_finish_wresp ? MEMR : MEMW;
            MEMR: state_d = rdat_m_valid ? FILL : MEMR;
            FILL: state_d = IDLE;
            FLCK: begin
                state_d = cdirty ? FLWB : last ? IDLE : FLCK;
                cnt_d   = cdirty ? cnt_q : cnt_q + 1'b1;
            end
            FLWB: state_d = FLWT;
            FLWT: begin
                state_d = !dcw_finish_wresp ? FLWT : last ? IDLE : FLCK;
                cnt_d   = dcw_finish_wresp ? cnt_q + 1'b1 : cnt_q;
            end
            default: state_d = IDLE;
        endcase
        if (rst_pipe) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        hit          = idle & cached & (m0 | m1);
        hit_way      = hit & m1;
        stall        = ~idle | miss;
        ram_ren      = (miss & vdirty) | ((state_q == FLCK) & cdirty);
        ram_radr     = !ram_ren ? '0 : idle ? {vic, idx} : cnt_q;
        ram_wen      = (state_q == MEMR) & rdat_m_valid;
        ram_wadr     = ram_wen ? {vic_q, idx_q} : '0;
        ram_wdata    = ram_wen ? rdat_m_data : '0;
        dcr_start_rq = (miss & ~vdirty) | ((state_q == MEMW) & dcw_finish_wresp);
        dcr_rin_addr = dcr_start_rq ? {(idle ? req_adr[31:4] : adr_q[31:4]), 4'h0} : '0;
        dcw_start_rq = (state_q == WBRQ) | (state_q == FLWB);
        dcw_in_data  = dcw_start_rq ? ram_rdata : '0;
        dcw_in_addr  = (state_q == WBRQ) ? {adr_q[31:28], tag_q[vic_q][idx_q], idx_q, 4'h0} :
                       (state_q == FLWB) ? {4'h0, tag_q[cway][cidx], cidx, 4'h0} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q <= '0;
            vic_q <= 1'b0;
        end else if (idle) begin
            adr_q <= req_adr;
            vic_q <= vic;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q[0]   <= '0;
            val_q[1]   <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
        end else if (clear_all) begin
            val_q[0]   <= '0;
            val_q[1]   <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
        end else begin
            if (hit) begin
                if (req_st) dirty_q[hit_way][idx] <= 1'b1;
                lru_q[idx] <= ~hit_way;
            end
            if (ram_wen) begin
                val_q[vic_q][idx_q]   <= 1'b1;
                dirty_q[vic_q][idx_q] <= 1'b0;
                lru_q[idx_q]          <= ~vic_q;
            end
        end
    end

    // Tags need no reset: a tag is only consulted when its valid bit is set.
    always_ff @(posedge clk) begin
        if (ram_wen) tag_q[vic_q][idx_q] <= adr_q[27:IDXW+4];
    end
endmodule

// File: tb/tb_dc_miss_ctrl_2way.sv
module tb_dc_miss_ctrl_2way;
    logic clk = 0, rst_n = 0, rst_pipe = 0, req_ld = 0, req_st = 0;
    logic [31:0] req_adr = 0;
    logic stall, hit, hit_way, ram_ren, ram_wen, dcw_start_rq, dcr_start_rq, dcflush_running;
    logic [9:0] ram_radr, ram_wadr;
    logic [127:0] ram_rdata = 0, ram_wdata, dcw_in_data, rdat_m_data = 0;
    logic [31:0] dcw_in_addr, dcr_rin_addr;
    logic dcw_finish_wresp = 0, rdat_m_valid = 0, start_dcflush = 0;
    int chk = 0, err = 0;
    int n_dcw = 0, n_dcr = 0, n_wen = 0;
    logic [9:0] last_wadr = 0;

    dc_miss_ctrl_2way dut (
        .clk(clk), .rst_n(rst_n), .rst_pipe(rst_pipe), .req_ld(req_ld), .req_st(req_st),
        .req_adr(req_adr), .stall(stall), .hit(hit), .hit_way(hit_way),
        .ram_ren(ram_ren), .ram_radr(ram_radr), .ram_rdata(ram_rdata),
        .ram_wen(ram_wen), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata),
        .dcw_start_rq(dcw_start_rq), .dcw_in_addr(dcw_in_addr), .dcw_in_data(dcw_in_data),
        .dcw_finish_wresp(dcw_finish_wresp), .dcr_start_rq(dcr_start_rq), .dcr_rin_addr(dcr_rin_addr),
        .rdat_m_data(rdat_m_data), .rdat_m_valid(rdat_m_valid),
        .start_dcflush(start_dcflush), .dcflush_running(dcflush_running)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (dcw_start_rq) n_dcw++;
        if (dcr_start_rq) n_dcr++;
        if (ram_wen) begin
            n_wen++;
            last_wadr = ram_wadr;
        end
    end

    // Run one request to completion with a memory that answers 3 cycles after each request.
    task automatic access(input logic ld, input logic st, input logic [31:0] a, output int cyc, output logic hw);
        int wc, rc;
        logic [31:0] ra;
        logic ok;
        wc = -1; rc = -1; ra = 0; ok = 0; hw = 0; cyc = 0;
        req_ld = ld; req_st = st; req_adr = a;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall) begin
                ok = 1; hw = hit_way; cyc = i;
                break;
            end
            if (dcw_start_rq) wc = 3;
            if (dcr_start_rq) begin
                rc = 3; ra = dcr_rin_addr;
            end
            @(negedge clk);
            wc--; rc--;
            dcw_finish_wresp = (wc == 0);
            rdat_m_valid = (rc == 0);
            rdat_m_data = {4{ra}};
        end
        chk++;
        if (!ok) begin
            err++;
            $display("FAIL access_timeout adr %h stall %b required 0", a, stall);
        end
        @(negedge clk);
        req_ld = 0; req_st = 0; dcw_finish_wresp = 0; rdat_m_valid = 0;
    endtask

    task automatic pipe_reset();
        @(negedge clk);
        req_ld = 0; req_st = 0; rst_pipe = 1;
        @(negedge clk);
        rst_pipe = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #23;
        chk++; if (stall !== 0) begin err++; $display("FAIL rst_stall got %b exp 0", stall); end
        chk++; if (hit !== 0) begin err++; $display("FAIL rst_hit got %b exp 0", hit); end
        chk++; if (dcr_start_rq !== 0) begin err++; $display("FAIL rst_dcr got %b exp 0", dcr_start_rq); end
        chk++; if (dcw_start_rq !== 0) begin err++; $display("FAIL rst_dcw got %b exp 0", dcw_start_rq); end
        chk++; if (ram_ren !== 0 || ram_wen !== 0) begin err++; $display("FAIL rst_ram got %b%b exp 00", ram_ren, ram_wen); end
        chk++; if (dcflush_running !== 0) begin err++; $display("FAIL rst_flush got %b exp 0", dcflush_running); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_load_miss();
        req_ld = 1; req_adr = 32'h0000_1230;
        #1;
        chk++; if (stall !== 1 || hit !== 0) begin err++; $display("FAIL lm_stall got %b/%b exp 1/0", stall, hit); end
        chk++; if (dcr_start_rq !== 1 || dcr_rin_addr !== 32'h0000_1230) begin err++; $display("FAIL lm_dcr got %b %h exp 1 00001230", dcr_start_rq, dcr_rin_addr); end
        chk++; if (ram_ren !== 0) begin err++; $display("FAIL lm_ren got %b exp 0", ram_ren); end
        @(negedge clk);
        #1;
        chk++; if (dcr_start_rq !== 0 || stall !== 1 || ram_wen !== 0) begin err++; $display("FAIL lm_memr got dcr %b stall %b wen %b exp 0 1 0", dcr_start_rq, stall, ram_wen); end
        rdat_m_valid = 1; rdat_m_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        #1;
        chk++; if (ram_wen !== 1 || ram_wadr !== 10'h123) begin err++; $display("FAIL lm_wen got %b %h exp 1 123", ram_wen, ram_wadr); end
        chk++; if (ram_wdata !== 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210) begin err++; $display("FAIL lm_wdata got %h", ram_wdata); end
        @(negedge clk);
        rdat_m_valid = 0;
        #1;
        chk++; if (stall !== 1 || hit !== 0) begin err++; $display("FAIL lm_fill got stall %b hit %b exp 1 0", stall, hit); end
        @(negedge clk);
        #1;
        chk++; if (hit !== 1 || hit_way !== 0 || stall !== 0) begin err++; $display("FAIL lm_replay got hit %b way %b stall %b exp 1 0 0", hit, hit_way, stall); end
        @(negedge clk);
        req_ld = 0;
    endtask

    task automatic test_lru();
        int cyc, w0, r0;
        logic hw;
        pipe_reset();
        access(1, 0, 32'h0000_1230, cyc, hw);
        chk++; if (last_wadr !== 10'h123 || cyc == 0) begin err++; $display("FAIL lru_first got wadr %h cyc %0d exp 123 >0", last_wadr, cyc); end
        access(1, 0, 32'h0020_1230, cyc, hw);
        chk++; if (last_wadr !== 10'h323 || hw !== 1) begin err++; $display("FAIL lru_second got wadr %h way %b exp 323 1", last_wadr, hw); end
        w0 = n_dcw; r0 = n_dcr;
        access(1, 0, 32'h0040_1230, cyc, hw);
        chk++; if (last_wadr !== 10'h123 || hw !== 0) begin err++; $display("FAIL lru_evict got wadr %h way %b exp 123 0", last_wadr, hw); end
        chk++; if (n_dcw != w0 || n_dcr != r0 + 1) begin err++; $display("FAIL lru_bus got dcw %0d dcr %0d exp 0 1", n_dcw - w0, n_dcr - r0); end
        access(1, 0, 32'h0020_1230, cyc, hw);
        chk++; if (cyc != 0 || hw !== 1) begin err++; $display("FAIL lru_keep got cyc %0d way %b exp 0 1", cyc, hw); end
    endtask

    task automatic test_store_wb();
        int cyc;
        logic hw;
        pipe_reset();
        access(1, 0, 32'h0000_1230, cyc, hw);
        access(0, 1, 32'h0000_1230, cyc, hw);
        chk++; if (cyc != 0) begin err++; $display("FAIL wb_sthit got cyc %0d exp 0", cyc); end
        access(1, 0, 32'h0020_1230, cyc, hw);
        req_ld = 1; req_adr = 32'h0040_1230;
        #1;
        chk++; if (ram_ren !== 1 || ram_radr !== 10'h123 || dcr_start_rq !== 0) begin err++; $display("FAIL wb_ren got %b %h dcr %b exp 1 123 0", ram_ren, ram_radr, dcr_start_rq); end
        @(negedge clk);
        ram_rdata = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        #1;
        chk++; if (dcw_start_rq !== 1 || dcw_in_addr !== 32'h0000_1230) begin err++; $display("FAIL wb_dcw got %b %h exp 1 00001230", dcw_start_rq, dcw_in_addr); end
        chk++; if (dcw_in_data !== 128'hdead_beef_0000_1111_2222_3333_4444_5555) begin err++; $display("FAIL wb_data got %h", dcw_in_data); end
        @(negedge clk);
        rdat_m_valid = 1;
        #1;
        chk++; if (dcw_start_rq !== 0 || dcr_start_rq !== 0 || ram_wen !== 0) begin err++; $display("FAIL wb_memw got dcw %b dcr %b wen %b exp 0 0 0", dcw_start_rq, dcr_start_rq, ram_wen); end
        @(negedge clk);
        rdat_m_valid = 0; dcw_finish_wresp = 1;
        #1;
        chk++; if (dcr_start_rq !== 1 || dcr_rin_addr !== 32'h0040_1230) begin err++; $display("FAIL wb_dcr got %b %h exp 1 00401230", dcr_start_rq, dcr_rin_addr); end
        @(negedge clk);
        dcw_finish_wresp = 0; rdat_m_valid = 1;
        #1;
        chk++; if (ram_wen !== 1 || ram_wadr !== 10'h123) begin err++; $display("FAIL wb_fill got %b %h exp 1 123", ram_wen, ram_wadr); end
        @(negedge clk);
        rdat_m_valid = 0;
        @(negedge clk);
        #1;
        chk++; if (hit !== 1 || hit_way !== 0) begin err++; $display("FAIL wb_replay got %b %b exp 1 0", hit, hit_way); end
        @(negedge clk);
        req_ld = 0;
    endtask

    task automatic test_uncached();
        int r0;
        r0 = n_dcr;
        req_ld = 1; req_adr = 32'hC000_0010;
        #1;
        chk++; if (hit !== 0 || stall !== 0) begin err++; $display("FAIL unc_hs got hit %b stall %b exp 0 0", hit, stall); end
        chk++; if (ram_ren !== 0 || dcr_start_rq !== 0 || dcw_start_rq !== 0) begin err++; $display("FAIL unc_bus got %b%b%b exp 000", ram_ren, dcr_start_rq, dcw_start_rq); end
        repeat (3) @(negedge clk);
        req_ld = 0;
        @(negedge clk);
        chk++; if (n_dcr != r0) begin err++; $display("FAIL unc_cnt got %0d exp 0", n_dcr - r0); end
    endtask

    task automatic test_rst_pipe();
        int w0;
        req_ld = 1; req_adr = 32'h0000_5670;
        #1;
        chk++; if (dcr_start_rq !== 1) begin err++; $display("FAIL rp_dcr got %b exp 1", dcr_start_rq); end
        @(negedge clk);
        @(negedge clk);
        req_ld = 0; rst_pipe = 1;
        @(negedge clk);
        rst_pipe = 0;
        #1;
        chk++; if (stall !== 0 || dcflush_running !== 0) begin err++; $display("FAIL rp_idle got stall %b fl %b exp 0 0", stall, dcflush_running); end
        w0 = n_wen;
        rdat_m_valid = 1;
        #1;
        chk++; if (ram_wen !== 0) begin err++; $display("FAIL rp_wen got %b exp 0", ram_wen); end
        @(negedge clk);
        rdat_m_valid = 0;
        @(negedge clk);
        chk++; if (n_wen != w0) begin err++; $display("FAIL rp_wcnt got %0d exp 0", n_wen - w0); end
        req_ld = 1; req_adr = 32'h0040_1230;
        #1;
        chk++; if (stall !== 1 || hit !== 0) begin err++; $display("FAIL rp_inval got stall %b hit %b exp 1 0", stall, hit); end
        pipe_reset();
    endtask

    task automatic test_flush();
        int cyc, w0, r0, np;
        logic hw, done;
        logic [31:0] a0, a1;
        pipe_reset();
        access(0, 1, 32'h0000_1230, cyc, hw);
        access(0, 1, 32'h0020_1240, cyc, hw);
        access(1, 0, 32'h0040_1250, cyc, hw);
        w0 = n_dcw; np = 0; a0 = 0; a1 = 0; done = 0;
        start_dcflush = 1;
`ifdef DC_FLUSH_EN
        @(negedge clk);
        start_dcflush = 0;
        #1;
        chk++; if (dcflush_running !== 1 || stall !== 1) begin err++; $display("FAIL fl_start got run %b stall %b exp 1 1", dcflush_running, stall); end
        for (int i = 0; i < 3000; i++) begin
            #1;
            if (!dcflush_running) begin
                done = 1;
                break;
            end
            if (dcw_start_rq) begin
                if (np == 0) a0 = dcw_in_addr;
                if (np == 1) a1 = dcw_in_addr;
                np++;
            end
            @(negedge clk);
            dcw_finish_wresp = dcw_start_rq ? 1'b0 : (dut.state_q == 3'd7);
        end
        dcw_finish_wresp = 0;
        chk++; if (!done) begin err++; $display("FAIL fl_timeout running %b exp 0", dcflush_running); end
        chk++; if (np != 2) begin err++; $display("FAIL fl_pulses got %0d exp 2", np); end
        chk++; if (a0 !== 32'h0000_1230 || a1 !== 32'h0020_1240) begin err++; $display("FAIL fl_addr got %h %h exp 00001230 00201240", a0, a1); end
        r0 = n_dcr;
        access(1, 0, 32'h0040_1250, cyc, hw);
        chk++; if (cyc == 0 || n_dcr != r0 + 1) begin err++; $display("FAIL fl_inval got cyc %0d dcr %0d exp >0 1", cyc, n_dcr - r0); end
`else
        @(negedge clk);
        start_dcflush = 0;
        #1;
        chk++; if (dcflush_running !== 0 || stall !== 0) begin err++; $display("FAIL fl_off got run %b stall %b exp 0 0", dcflush_running, stall); end
        repeat (4) @(negedge clk);
        chk++; if (n_dcw != w0) begin err++; $display("FAIL fl_off_dcw got %0d exp 0", n_dcw - w0); end
        access(1, 0, 32'h0040_1250, cyc, hw);
        chk++; if (cyc != 0 || np != 0 || done !== 0 || a0 !== a1) begin err++; $display("FAIL fl_off_keep got cyc %0d exp 0", cyc); end
        r0 = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_lru();
        test_store_wb();
        test_uncached();
        test_rst_pipe();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
